// File: rtl/ice_cream_dispense_ctrl_pkg.sv
// Shared types and constants for the ice-cream dispense scheduler.
package ice_cream_dispense_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCOOP = 3'd1,
        ST_GAP   = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam int MAX_BALLS       = 2;
    localparam int BALL_W          = 2;
    localparam int DEFAULT_TIMEOUT = 15;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Ball code 3 is not a legal order; treat it as the maximum.
    function automatic logic [BALL_W-1:0] clamp_balls(input logic [BALL_W-1:0] b);
        return (b > BALL_W'(MAX_BALLS)) ? BALL_W'(MAX_BALLS) : b;
    endfunction

endpackage

// File: rtl/ice_cream_dispense_ctrl_if.sv
// Kiosk order, scoop mechanism and completion signals of the dispense scheduler.
interface ice_cream_dispense_ctrl_if
    import ice_cream_dispense_ctrl_pkg::*;
#(
    parameter int N_KIOSKS = 2
) ();
    localparam int ID_W = id_width(N_KIOSKS);

    logic [N_KIOSKS-1:0]        order_valid;
    logic [BALL_W*N_KIOSKS-1:0] order_balls;
    logic [N_KIOSKS-1:0]        order_ready;
    logic                       scoop_req;
    logic                       scoop_done;
    logic                       served_valid;
    logic [ID_W-1:0]            served_id;
    logic                       busy;
    logic                       fault;
    logic                       fault_clr;

    modport master (
        input  order_valid, order_balls, scoop_done, fault_clr,
        output order_ready, scoop_req, served_valid, served_id, busy, fault
    );

    modport slave (
        output order_valid, order_balls, scoop_done, fault_clr,
        input  order_ready, scoop_req, served_valid, served_id, busy, fault
    );

endinterface

// File: rtl/ice_cream_rr_arbiter.sv
// Round-robin one-hot picker: first requester above ptr, wrapping around.
// Purely combinational; grant is zero when disabled or nothing requests.
module ice_cream_rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             enable,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int off = 1; off <= N; off++) begin
            cand = IDX_W'((int'(ptr) + off) % N);
            if (enable && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ice_cream_dispense_ctrl.sv
// Round-robin order scheduler driving one shared scoop mechanism (optional stats: ICE_CREAM_STATS_EN).
// Latency: grant -> scoop_req next cycle; served_valid one cycle after the last scoop_done.
// Backpressure: grants only in IDLE; mechanism stalls beyond TIMEOUT cycles raise a sticky fault.
module ice_cream_dispense_ctrl
    import ice_cream_dispense_ctrl_pkg::*;
#(
    parameter int N_KIOSKS = 2,
    parameter int TIMEOUT  = DEFAULT_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    ice_cream_dispense_ctrl_if.master bus
`ifdef ICE_CREAM_STATS_EN
    ,
    output logic [15:0]              served_total
`endif
);

    localparam int ID_W  = id_width(N_KIOSKS);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  PTR_RST  = ID_W'(N_KIOSKS - 1);

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     id_q;
    logic [ID_W-1:0]     gnt_idx;
    logic [ID_W-1:0]     served_id_q;
    logic [N_KIOSKS-1:0] gnt;
    logic [BALL_W-1:0]   remaining;
    logic [BALL_W-1:0]   sel_balls;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                scoop_req_q;
    logic                served_valid_q;
    logic                busy_q;
    logic                fault_q;
    logic                take;

    ice_cream_rr_arbiter #(
        .N     (N_KIOSKS),
        .IDX_W (ID_W)
    ) u_arb (
        .req       (bus.order_valid),
        .ptr       (rr_ptr),
        .enable    (state == ST_IDLE),
        .grant     (gnt),
        .grant_idx (gnt_idx)
    );

    assign take      = |gnt;
    assign sel_balls = clamp_balls(bus.order_balls[int'(gnt_idx)*BALL_W +: BALL_W]);

    assign bus.order_ready  = gnt;
    assign bus.scoop_req    = scoop_req_q;
    assign bus.served_valid = served_valid_q;
    assign bus.served_id    = served_id_q;
    assign bus.busy         = busy_q;
    assign bus.fault        = fault_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            rr_ptr         <= PTR_RST;
            id_q           <= '0;
            remaining      <= '0;
            tmo_cnt        <= '0;
            scoop_req_q    <= 1'b0;
            served_valid_q <= 1'b0;
            served_id_q    <= '0;
            busy_q         <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            served_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        id_q      <= gnt_idx;
                        rr_ptr    <= gnt_idx;
                        remaining <= sel_balls;
                        tmo_cnt   <= '0;
                        busy_q    <= 1'b1;
                        if (sel_balls != '0) begin
                            state       <= ST_SCOOP;
                            scoop_req_q <= 1'b1;
                        end else begin
                            state          <= ST_DONE;
                            served_valid_q <= 1'b1;
                            served_id_q    <= gnt_idx;
                        end
                    end
                end
                ST_SCOOP: begin
                    // A delivery in the final allowed cycle still counts.
                    if (bus.scoop_done) begin
                        remaining   <= remaining - 1'b1;
                        tmo_cnt     <= '0;
                        scoop_req_q <= 1'b0;
                        if (remaining == BALL_W'(MAX_BALLS)) begin
                            state <= ST_GAP;
                        end else begin
                            state          <= ST_DONE;
                            served_valid_q <= 1'b1;
                            served_id_q    <= id_q;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state       <= ST_FAULT;
                        scoop_req_q <= 1'b0;
                        fault_q     <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    state       <= ST_SCOOP;
                    scoop_req_q <= 1'b1;
                    tmo_cnt     <= '0;
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                ST_FAULT: begin
                    if (bus.fault_clr) begin
                        state     <= ST_IDLE;
                        fault_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        remaining <= '0;
                        tmo_cnt   <= '0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    scoop_req_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef ICE_CREAM_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            served_total <= '0;
        end else if (state == ST_SCOOP && bus.scoop_done && served_total != 16'hFFFF) begin
            served_total <= served_total + 16'd1;
        end
    end

    a_state_legal: assert property (@(posedge clk) disable iff (reset)
        state inside {ST_IDLE, ST_SCOOP, ST_GAP, ST_DONE, ST_FAULT});
    a_req_in_scoop: assert property (@(posedge clk) disable iff (reset)
        bus.scoop_req |-> state == ST_SCOOP);
    a_ready_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0(bus.order_ready));
`endif

endmodule

// File: tb/tb_ice_cream_dispense_ctrl.sv
// Directed bench for ice_cream_dispense_ctrl with a delayed-response scoop mechanism model.
module tb_ice_cream_dispense_ctrl;

    localparam int N   = 2;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic reset;
`ifdef ICE_CREAM_STATS_EN
    logic [15:0] served_total;
`endif

    ice_cream_dispense_ctrl_if #(.N_KIOSKS(N)) bus ();

    ice_cream_dispense_ctrl #(
        .N_KIOSKS (N),
        .TIMEOUT  (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ICE_CREAM_STATS_EN
        ,
        .served_total (served_total)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Activity monitor, sampled mid-cycle.
    int         n_rise    = 0;
    int         n_req_cyc = 0;
    int         n_served  = 0;
    int         n_grant   = 0;
    int         n_same    = 0;
    logic       prev_req  = 1'b0;
    logic       last_gid  = 1'b0;
    logic       last_sid  = 1'b0;
    logic [7:0] gseq      = '0;

    always @(negedge clk) begin
        prev_req <= bus.scoop_req;
        if (bus.scoop_req && !prev_req) n_rise <= n_rise + 1;
        if (bus.scoop_req) n_req_cyc <= n_req_cyc + 1;
        if (bus.served_valid) begin
            n_served <= n_served + 1;
            last_sid <= bus.served_id;
        end
        if (|(bus.order_valid & bus.order_ready)) begin
            n_grant <= n_grant + 1;
            if (n_grant != 0 && bus.order_ready[1] == last_gid) n_same <= n_same + 1;
            last_gid <= bus.order_ready[1];
            gseq     <= {gseq[6:0], bus.order_ready[1]};
        end
    end

    // Mechanism model: answers mech_dly cycles after scoop_req rises.
    logic mech_en    = 1'b0;
    logic force_done = 1'b0;
    int   mech_dly   = 0;
    int   mech_age   = 0;

    initial begin
        bus.scoop_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (mech_en && bus.scoop_req) begin
                bus.scoop_done = (mech_age == mech_dly);
                mech_age++;
            end else begin
                bus.scoop_done = force_done;
                mech_age = 0;
            end
        end
    end

    int b_rise, b_req, b_srv, b_grant, b_same;

    initial begin
        reset           = 1'b1;
        bus.order_valid = '0;
        bus.order_balls = '0;
        bus.fault_clr   = 1'b0;
        tick(2);
        chk_eq("rst_scoop_req", bus.scoop_req, 0);
        chk_eq("rst_busy", bus.busy, 0);
        chk_eq("rst_served_valid", bus.served_valid, 0);
        chk_eq("rst_served_id", bus.served_id, 0);
        chk_eq("rst_fault", bus.fault, 0);
        chk_eq("rst_order_ready", bus.order_ready, 0);
`ifdef ICE_CREAM_STATS_EN
        chk_eq("rst_served_total", served_total, 0);
`endif
        reset = 1'b0;
        tick(1);

        // Single 2-ball order from kiosk 0, mechanism answers after 3 cycles.
        mech_en = 1'b1; mech_dly = 3;
        b_rise = n_rise; b_srv = n_served; b_req = n_req_cyc;
        bus.order_balls = 4'b0010; bus.order_valid = 2'b01;
        #1;
        chk_eq("t1_grant", bus.order_ready, 1);
        tick(1);
        bus.order_valid = '0;
        chk_eq("t1_req_first", bus.scoop_req, 1);
        chk_eq("t1_busy", bus.busy, 1);
        tick(4);
        chk_eq("t1_gap_req", bus.scoop_req, 0);
        tick(1);
        chk_eq("t1_req_second", bus.scoop_req, 1);
        tick(4);
        chk_eq("t1_served_valid", bus.served_valid, 1);
        chk_eq("t1_served_id", bus.served_id, 0);
        tick(1);
        chk_eq("t1_busy_after", bus.busy, 0);
        chk_eq("t1_req_bursts", n_rise - b_rise, 2);
        chk_eq("t1_req_cycles", n_req_cyc - b_req, 8);
        chk_eq("t1_served_count", n_served - b_srv, 1);

        // Contention: both kiosks always valid, 1-ball orders.
        mech_dly = 1;
        b_grant = n_grant; b_same = n_same; b_srv = n_served;
        bus.order_balls = 4'b0101; bus.order_valid = 2'b11;
        #1;
        chk_eq("t2_first_grant", bus.order_ready, 2);
        tick(13);
        bus.order_valid = '0;
        tick(3);
        chk_eq("t2_busy_after", bus.busy, 0);
        chk_eq("t2_grants", n_grant - b_grant, 4);
        chk_eq("t2_repeat_grants", n_same - b_same, 0);
        chk_eq("t2_grant_order", gseq[3:0], 4'b1010);
        chk_eq("t2_served_count", n_served - b_srv, 4);
        chk_eq("t2_last_id", last_sid, 0);

        // Zero-ball order from kiosk 1.
        b_rise = n_rise;
        bus.order_balls = 4'b0000; bus.order_valid = 2'b10;
        #1;
        chk_eq("t3_zero_grant", bus.order_ready, 2);
        tick(1);
        chk_eq("t3_zero_served", bus.served_valid, 1);
        chk_eq("t3_zero_id", bus.served_id, 1);
        chk_eq("t3_zero_req", bus.scoop_req, 0);
        bus.order_valid = '0;
        tick(1);
        chk_eq("t3_zero_pulse_end", bus.served_valid, 0);
        chk_eq("t3_zero_no_scoop", n_rise - b_rise, 0);

        // Illegal ball code 3 from kiosk 0 is treated as 2.
        b_rise = n_rise; b_srv = n_served; b_req = n_req_cyc;
        bus.order_balls = 4'b0011; bus.order_valid = 2'b01;
        tick(1);
        bus.order_valid = '0;
        tick(6);
        chk_eq("t3_clamp_busy", bus.busy, 0);
        chk_eq("t3_clamp_scoops", n_rise - b_rise, 2);
        chk_eq("t3_clamp_req_cycles", n_req_cyc - b_req, 4);
        chk_eq("t3_clamp_served", n_served - b_srv, 1);
        chk_eq("t3_clamp_id", last_sid, 0);

        // Mechanism never answers: fault after TMO cycles of scoop_req.
        mech_en = 1'b0;
        b_grant = n_grant; b_srv = n_served; b_req = n_req_cyc;
        bus.order_balls = 4'b0100; bus.order_valid = 2'b10;
        tick(15);
        chk_eq("t4_req_last", bus.scoop_req, 1);
        chk_eq("t4_no_fault_yet", bus.fault, 0);
        tick(1);
        chk_eq("t4_fault", bus.fault, 1);
        chk_eq("t4_req_drop", bus.scoop_req, 0);
        chk_eq("t4_no_grant", bus.order_ready, 0);
        chk_eq("t4_busy", bus.busy, 1);
        tick(5);
        chk_eq("t4_fault_sticky", bus.fault, 1);
        chk_eq("t4_grants", n_grant - b_grant, 1);
        chk_eq("t4_no_served", n_served - b_srv, 0);
        chk_eq("t4_req_cycles", n_req_cyc - b_req, TMO);
        bus.fault_clr = 1'b1;
        tick(1);
        bus.fault_clr = 1'b0;
        chk_eq("t4_fault_cleared", bus.fault, 0);
        chk_eq("t4_idle_busy", bus.busy, 0);
        chk_eq("t4_regrant", bus.order_ready, 2);
        mech_en = 1'b1; mech_dly = 1;
        tick(1);
        bus.order_valid = '0;
        tick(2);
        chk_eq("t4_recover_served", bus.served_valid, 1);
        chk_eq("t4_recover_id", bus.served_id, 1);
        tick(1);

        // Reset in the middle of a scoop, then a stray scoop_done.
        mech_en = 1'b0;
        b_srv = n_served;
        bus.order_balls = 4'b0001; bus.order_valid = 2'b01;
        tick(1);
        bus.order_valid = '0;
        tick(1);
        reset = 1'b1;
        tick(1);
        chk_eq("t5_req_dropped", bus.scoop_req, 0);
        chk_eq("t5_busy_dropped", bus.busy, 0);
        reset = 1'b0;
        force_done = 1'b1;
        tick(1);
        force_done = 1'b0;
        chk_eq("t5_stray_served", bus.served_valid, 0);
        chk_eq("t5_stray_busy", bus.busy, 0);
        chk_eq("t5_stray_req", bus.scoop_req, 0);
        bus.order_valid = 2'b11;
        #1;
        chk_eq("t5_ptr_reset", bus.order_ready, 1);
        bus.order_valid = '0;
        tick(2);
        chk_eq("t5_no_served", n_served - b_srv, 0);
        chk_eq("t5_no_fault", bus.fault, 0);

        // scoop_done arrives in the last allowed SCOOP cycle.
        mech_en = 1'b1; mech_dly = TMO - 1;
        bus.order_balls = 4'b0100; bus.order_valid = 2'b10;
        tick(1);
        bus.order_valid = '0;
        tick(14);
        chk_eq("t6_req_15th", bus.scoop_req, 1);
        chk_eq("t6_fault_15th", bus.fault, 0);
        tick(1);
        chk_eq("t6_served", bus.served_valid, 1);
        chk_eq("t6_served_id", bus.served_id, 1);
        chk_eq("t6_no_fault", bus.fault, 0);
`ifdef ICE_CREAM_STATS_EN
        chk_eq("t6_served_total", served_total, 1);
`endif
        tick(2);
        chk_eq("t6_busy_after", bus.busy, 0);
        chk_eq("t6_fault_after", bus.fault, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ice_cream_dispense_ctrl.md
Name: ice_cream_dispense_ctrl

Overview:
- Shared-dispenser scheduler for the ice-cream vending line.
- N kiosk front-ends (coin-counting Moore FSMs) each present an order of 0-2 balls. This block picks one order round-robin and sequences a single shared scoop mechanism, one ball at a time, over a req/done handshake.
- Reports completion per order, and raises a sticky fault if the mechanism stalls.

Parameters:
- N_KIOSKS, 2, number of requesting kiosks (2..8).
- TIMEOUT, 15, maximum cycles scoop_req may stay high without scoop_done before fault.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- order_valid  in  N_KIOSKS  kiosk i has a pending order.
- order_balls  in  2*N_KIOSKS  ball count for kiosk i, bits [2i+1:2i].
- order_ready  out  N_KIOSKS  one-hot grant; order i transfers when order_valid[i] & order_ready[i].
- scoop_req  out  1  request one scoop from the mechanism, registered.
- scoop_done  in  1  one-cycle pulse: the mechanism has delivered a ball.
- served_valid  out  1  one-cycle pulse: granted order is complete.
- served_id  out  $clog2(N_KIOSKS)  kiosk index of the completed order; valid with served_valid.
- busy  out  1  high in any state other than IDLE.
- fault  out  1  sticky stall indication.
- fault_clr  in  1  clears the fault and returns the block to IDLE.

Behaviour:
- Reset values:
  - state = IDLE, rr_ptr = N_KIOSKS-1 (so kiosk 0 has priority first).
  - order_ready = 0, scoop_req = 0, served_valid = 0, served_id = 0, busy = 0, fault = 0.
  - Timeout counter = 0, remaining = 0.
- States: IDLE, SCOOP, GAP, DONE, FAULT.
- IDLE:
  - order_ready is combinational. It is one-hot on the first valid kiosk searching upward from rr_ptr+1 with wrap-around, and 0 when none is valid.
  - On transfer: latch kiosk id, set rr_ptr = id, set remaining = order_balls[id].
  - Next state: SCOOP if remaining != 0, DONE if remaining == 0.
  - Value 3 is illegal and is clamped to 2.
- SCOOP:
  - scoop_req = 1 (Moore output of registered state). The timeout counter increments each cycle.
  - When scoop_done = 1: remaining decrements and the counter clears. Next state is GAP if remaining was 2, DONE if remaining was 1.
  - When the counter reaches TIMEOUT with no scoop_done, go to FAULT.
  - scoop_done and timeout in the same cycle: done wins.
- GAP: one cycle with scoop_req = 0 (mechanism re-arm), then SCOOP.
- DONE: served_valid = 1 and served_id = latched id for exactly one cycle, then IDLE.
  - Back-to-back orders therefore have at least one idle cycle between grants.
- FAULT:
  - fault = 1 and scoop_req = 0. No grants are issued; the latched order is discarded and served_valid is not produced.
  - fault_clr = 1 moves to IDLE next cycle with fault cleared. fault_clr in any other state is ignored.
- Inputs ignored outside their window:
  - scoop_done outside SCOOP is ignored.
  - order_valid changes outside IDLE are ignored.
  - A kiosk is expected to hold order_valid and order_balls stable until it is granted.
- Latency:
  - 1-ball order: grant at t, scoop_req high from t+1; done at t+k gives served_valid at t+k+1.
  - 0-ball order: served_valid at t+1, scoop_req never asserts.
- Fairness: a continuously valid kiosk is granted within N_KIOSKS grants.
- reset mid-operation: immediate return to reset values. Any in-flight order is lost, and scoop_req drops the next cycle.

Optional Feature:
- Macro: ICE_CREAM_STATS_EN.
- When defined:
  - Extra output served_total (16 bits). It counts balls actually delivered, incrementing on each accepted scoop_done in SCOOP.
  - The counter saturates at 16'hFFFF and is cleared by reset only.
  - Formal asserts are added: state always legal, scoop_req implies state==SCOOP, order_ready one-hot-or-zero.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package:
  - State encodings IDLE/SCOOP/GAP/DONE/FAULT.
  - MAX_BALLS = 2.
  - Ball-count width (2).
  - Default TIMEOUT.
- One natural sub-module: ice_cream_rr_arbiter.
  - Parameter N.
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.

Test Plan:
- Single order: kiosk0 order 2 balls; scoop_done 3 cycles after each scoop_req rise -> order_ready[0] pulse at t, two scoop_req bursts separated by one GAP cycle, served_valid with served_id=0 exactly once, busy low after.
- Contention: both kiosks valid continuously with 1-ball orders; scoop_done 1 cycle after each scoop_req rise -> grants alternate 0,1,0,1, with no kiosk granted twice in a row.
- Zero and illegal orders: kiosk1 order 0 -> served_valid next cycle, scoop_req never high. Kiosk0 order 3 -> exactly 2 scoops.
- Timeout: 1-ball order, scoop_done never arrives -> fault=1 after TIMEOUT=15 cycles of scoop_req, scoop_req drops, no grants while valid. fault_clr -> IDLE, next order served normally.
- Reset mid-scoop: reset asserted during SCOOP -> next cycle scoop_req=0, busy=0, no served_valid. A stray scoop_done afterwards is ignored.
- Done/timeout race (with ICE_CREAM_STATS_EN): scoop_done in the 15th SCOOP cycle -> no fault, served_valid issued, served_total increments by 1.
